// File: rtl/seq_divider_if.sv
// Start/valid handshake between the control sequencer (master) and the
// sequential divider (slave).
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divzero;

    modport master (
        output start, dividend, divisor,
        input  busy, valid, quotient, remainder, divzero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, valid, quotient, remainder, divzero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned divider: restoring shift-and-subtract, one quotient
// bit per clock. A zero divisor short-circuits straight to the result.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    seq_divider_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_busy;
    logic               w_valid;
    logic               w_accept;

    // The partial remainder is kept WIDTH bits wide: after every restoring
    // step it is below the divisor, so its extra top bit is always zero.
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_divzero;

    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_trial_ok;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic               w_last;

    // One restoring step: shift in the next dividend bit, try subtracting
    // the divisor via two's complement, keep the difference if non-negative.
    always_comb begin
        w_rem_shift = {r_rem, r_quo[WIDTH-1]};
        w_trial     = w_rem_shift + ~{1'b0, r_div} + (WIDTH+1)'(1);
        w_trial_ok  = ~w_trial[WIDTH];
        w_rem_next  = w_trial_ok ? w_trial[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
        w_quo_next  = {r_quo[WIDTH-2:0], w_trial_ok};
        w_last      = (r_cnt == CNT_W'(WIDTH - 1));
    end

    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // State register; reset wins over everything else.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block order.
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start)
                    w_next_state = (bus.divisor == '0) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_valid = 1'b1;
                if (bus.start)
                    w_next_state = (bus.divisor == '0) ? S_DONE : S_CALC;
                else
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers that hold
    // their value until the next result is loaded.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divzero   <= 1'b0;
        end else if (w_accept) begin
            if (bus.divisor != '0) begin
                r_rem <= '0;
                r_quo <= bus.dividend;
                r_div <= bus.divisor;
                r_cnt <= '0;
            end else begin
                r_quotient  <= '1;
                r_remainder <= bus.dividend;
                r_divzero   <= 1'b1;
            end
        end else if (r_state == S_CALC) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_quotient  <= w_quo_next;
                r_remainder <= w_rem_next;
                r_divzero   <= 1'b0;
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.valid     = w_valid;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.divzero   = r_divzero;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, an exhaustive sweep
// and randomized operations against an arithmetic reference model.
module tb_seq_divider;
    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic i_clk = 1'b0;
    logic i_reset;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    seq_divider_if #(.WIDTH(WIDTH)) bus_if ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus_if)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reference: plain integer division; zero divisor gives all ones / dividend.
    function automatic void ref_div(input int unsigned a, input int unsigned b,
                                    output int unsigned q, output int unsigned r,
                                    output int unsigned dz);
        if (b == 0) begin
            q = MAXV; r = a; dz = 1;
        end else begin
            q = a / b; r = a % b; dz = 0;
        end
    endfunction

    // One full division with START pulsed for one accepting edge.
    task automatic do_div(input int unsigned a, input int unsigned b, input string tag);
        int unsigned q, r, dz;
        int lat;
        int busy_cycles;
        ref_div(a, b, q, r, dz);
        bus_if.start    = 1'b1;
        bus_if.dividend = WIDTH'(a);
        bus_if.divisor  = WIDTH'(b);
        tick();
        bus_if.start    = 1'b0;
        bus_if.dividend = WIDTH'($urandom);
        bus_if.divisor  = WIDTH'($urandom);
        lat = 0;
        busy_cycles = 0;
        while (!bus_if.valid && lat < 20) begin
            if (bus_if.busy) busy_cycles++;
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, (b == 0) ? 0 : WIDTH);
        check({tag, "_busy_cycles"}, busy_cycles, (b == 0) ? 0 : WIDTH);
        check({tag, "_busy_with_valid"}, bus_if.busy, 0);
        check({tag, "_q"}, bus_if.quotient, q);
        check({tag, "_r"}, bus_if.remainder, r);
        check({tag, "_dz"}, bus_if.divzero, dz);
        if (b != 0) begin
            check({tag, "_invariant"}, bus_if.quotient * b + bus_if.remainder, a);
            check({tag, "_rem_lt_div"}, int'(bus_if.remainder < b), 1);
        end
        tick();
        check({tag, "_valid_one_cycle"}, bus_if.valid, 0);
        check({tag, "_q_hold"}, bus_if.quotient, q);
    endtask

    initial begin
        int unsigned a, b;
        int n_valid;
        int t_valid [2];
        int unsigned q_seen [2];
        int unsigned r_seen [2];
        int i;

        i_reset         = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;
        tick();
        tick();
        i_reset = 1'b0;
        check("reset_busy", bus_if.busy, 0);
        check("reset_valid", bus_if.valid, 0);
        check("reset_q", bus_if.quotient, 0);
        check("reset_r", bus_if.remainder, 0);
        check("reset_dz", bus_if.divzero, 0);

        do_div(13, 4, "d13_4");
        do_div(15, 1, "d15_1");
        do_div(3, 9, "d3_9");
        do_div(15, 15, "d15_15");
        do_div(7, 0, "d7_0");
        do_div(6, 3, "d6_3");

        // START during CALC is ignored.
        bus_if.start = 1'b1; bus_if.dividend = 4'd13; bus_if.divisor = 4'd4;
        tick();
        bus_if.start = 1'b0;
        tick();
        bus_if.start = 1'b1; bus_if.dividend = 4'd9; bus_if.divisor = 4'd2;
        tick();
        bus_if.start = 1'b0;
        n_valid = 0;
        for (int k = 0; k < 14; k++) begin
            if (bus_if.valid) begin
                n_valid++;
                check("ign_q", bus_if.quotient, 3);
                check("ign_r", bus_if.remainder, 1);
            end
            tick();
        end
        check("ign_valid_count", n_valid, 1);
        check("ign_idle_busy", bus_if.busy, 0);

        // Reset in the middle of CALC aborts the operation.
        bus_if.start = 1'b1; bus_if.dividend = 4'd14; bus_if.divisor = 4'd3;
        tick();
        bus_if.start = 1'b0;
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("abort_busy", bus_if.busy, 0);
        check("abort_q", bus_if.quotient, 0);
        check("abort_r", bus_if.remainder, 0);
        n_valid = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus_if.valid || bus_if.busy) n_valid++;
            tick();
        end
        check("abort_no_activity", n_valid, 0);
        do_div(14, 3, "d14_3_after_abort");

        // START held high: results every WIDTH+1 cycles.
        bus_if.start = 1'b1; bus_if.dividend = 4'd13; bus_if.divisor = 4'd4;
        tick();
        bus_if.dividend = 4'd10; bus_if.divisor = 4'd3;
        n_valid = 0;
        i = 0;
        while (n_valid < 2 && i < 30) begin
            if (bus_if.valid) begin
                t_valid[n_valid] = i;
                q_seen[n_valid]  = bus_if.quotient;
                r_seen[n_valid]  = bus_if.remainder;
                n_valid++;
            end else if (n_valid == 1) begin
                check("b2b_hold_q", bus_if.quotient, 3);
                check("b2b_hold_r", bus_if.remainder, 1);
            end
            if (n_valid == 2) bus_if.start = 1'b0;
            tick();
            i++;
        end
        bus_if.start = 1'b0;
        check("b2b_pulses", n_valid, 2);
        if (n_valid == 2) begin
            check("b2b_first_at", t_valid[0], WIDTH);
            check("b2b_gap", t_valid[1] - t_valid[0], WIDTH + 1);
            check("b2b_q0", q_seen[0], 3);
            check("b2b_r0", r_seen[0], 1);
            check("b2b_q1", q_seen[1], 3);
            check("b2b_r1", r_seen[1], 1);
        end
        check("b2b_idle_valid", bus_if.valid, 0);
        check("b2b_idle_busy", bus_if.busy, 0);

        // Exhaustive sweep of all operand pairs.
        for (int x = 0; x <= MAXV; x++)
            for (int y = 0; y <= MAXV; y++)
                do_div(x, y, "sweep");

        // Randomized operations with random idle gaps.
        for (int k = 0; k < 150; k++) begin
            a = $urandom_range(MAXV, 0);
            b = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(MAXV, 1);
            repeat ($urandom_range(2, 0)) tick();
            do_div(a, b, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential unsigned integer divider producing quotient and remainder by restoring shift-and-subtract, one quotient bit per clock. It is the inverse counterpart of the combinational adder/subtractor: it performs division as repeated two's-complement subtraction. It sits beside the adder in the processing unit's arithmetic section and is driven by a single-word START/VALID handshake from the control sequencer.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)
- CLK  input  1  clock; all state changes on the rising edge
- RESET  input  1  synchronous, active-high reset
- START  input  1  request a division; sampled only when the block is accepting (IDLE or DONE)
- DIVIDEND  input  WIDTH  unsigned dividend; sampled on the accepting edge
- DIVISOR  input  WIDTH  unsigned divisor; sampled on the accepting edge
- BUSY  output  1  high while a division is in progress (CALC state)
- VALID  output  1  one-cycle pulse: QUOTIENT/REMAINDER/DIVZERO hold a new result
- QUOTIENT  output  WIDTH  unsigned quotient
- REMAINDER  output  WIDTH  unsigned remainder
- DIVZERO  output  1  last result was a divide by zero

## Operation
- States: IDLE, CALC, DONE.
- IDLE: BUSY=0, VALID=0. START=1 accepts the operands.
  - DIVISOR≠0: load R←0 (WIDTH+1 bits), Q←DIVIDEND, D←DIVISOR, step counter←0. Go to CALC.
  - DIVISOR=0: go directly to DONE with QUOTIENT←all ones, REMAINDER←DIVIDEND, DIVZERO←1.
- CALC: BUSY=1. Each edge performs one step:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - T = R' + ~{1'b0,D} + 1, computed in WIDTH+1 bits. The carry-out of the extended sum is no-borrow.
  - T non-negative (MSB of T = 0): R←T, Q←{Q[WIDTH-2:0],1}. Otherwise R←R', Q←{Q[WIDTH-2:0],0}.
  - Counter increments. The edge performing step WIDTH-1 also loads QUOTIENT←final Q, REMAINDER←final R[WIDTH-1:0], DIVZERO←0, and goes to DONE.
- DONE: VALID=1, BUSY=0, lasting exactly one cycle.
  - START=1 accepts new operands exactly as in IDLE, allowing back-to-back operations.
  - Otherwise go to IDLE.
- QUOTIENT, REMAINDER and DIVZERO change only on the result-loading edge. They hold their value through IDLE and through a subsequent CALC until the next result is loaded.
- START while in CALC is ignored. It is not queued.
- DIVIDEND and DIVISOR are don't-care except on the accepting edge. Internal copies are used during CALC.
- Invariant for every non-zero divisor: DIVIDEND = QUOTIENT·DIVISOR + REMAINDER, with REMAINDER < DIVISOR.

## Timing
- Reset (synchronous, RESET=1 at an edge): state IDLE, BUSY=0, VALID=0, QUOTIENT=0, REMAINDER=0, DIVZERO=0, internal R/Q/D/counter=0.
  - RESET has priority over START and over any in-progress operation.
  - Reset mid-CALC aborts the operation: no VALID, and the outputs return to 0.
- Normal latency: START accepted at edge E0 → BUSY=1 from E0 to E_WIDTH → VALID=1 for the cycle after E_WIDTH.
  - For WIDTH=4, VALID is seen 4 cycles after the accepting edge.
- Divide by zero latency: VALID=1 for the cycle after E0. BUSY never asserts.
- Back-to-back: START held high continuously yields one result every WIDTH+1 cycles (non-zero divisors). The DONE cycle doubles as the next accepting cycle.
- BUSY and VALID are never high in the same cycle.

## Test plan
- Reset, then DIVIDEND=13, DIVISOR=4, START pulse → BUSY high 4 cycles, then VALID pulse with QUOTIENT=3, REMAINDER=1, DIVZERO=0.
- 15/1 → QUOTIENT=15, REMAINDER=0. 3/9 → QUOTIENT=0, REMAINDER=3. 15/15 → 1, 0. Exhaustive sweep of all 256 operand pairs checks the invariant and the divide-by-zero rule.
- DIVIDEND=7, DIVISOR=0 → VALID in the cycle after the accepting edge, QUOTIENT=15, REMAINDER=7, DIVZERO=1, BUSY stays 0. A following 6/3 → QUOTIENT=2, REMAINDER=0, DIVZERO=0.
- Start 13/4, then pulse START with 9/2 during CALC cycle 2 → only the single result 3/1 is produced, and the block returns to IDLE.
- Start 14/3, assert RESET in CALC cycle 2 → no VALID, outputs=0, state IDLE. Next 14/3 completes normally with 4, 2.
- START held high with operands changing at each accepting edge (13/4, then 10/3) → VALID pulses exactly 5 cycles apart with results 3/1 and 3/1. The first result holds until the second result is loaded.
